// File: rtl/spi_cmd_sequencer_if.sv
// Register-file write bus between the SPI command sequencer (master) and the
// configuration register bank (slave).
interface spi_cmd_sequencer_if #(
   parameter int ADDR_W = 7
);
   logic              regWe;
   logic [ADDR_W-1:0] regAddr;
   logic [7:0]        regWdata;

   modport master (output regWe, regAddr, regWdata);
   modport slave  (input  regWe, regAddr, regWdata);
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Decodes bytes from the SPI receive buffer into burst register writes.
// Optional idle-timeout abort is enabled by defining SPI_CMD_SEQ_TIMEOUT_EN.
module spi_cmd_sequencer #(
   parameter int ADDR_W      = 7,
   parameter int MAX_BURST   = 16,
   parameter int SYNC_STAGES = 2
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 4096
`endif
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       spi_cs_i,
   input  logic [7:0]                 byte_i,
   input  logic                       byte_valid_i,
   spi_cmd_sequencer_if.master        regBus,
   output logic                       busy_o,
   output logic                       frame_done_o,
   output logic [7:0]                 byte_count_o,
   output logic                       overrun_o
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
   ,
   output logic                       timeout_o
`endif
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA,
      DISCARD
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] csSync_q;
   logic [SYNC_STAGES-1:0] validSync_q;
   logic                   validPrev_q;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [CNT_W-1:0]       dataCnt_q, dataCnt_d;
   logic                   regWe_q, regWe_d;
   logic [ADDR_W-1:0]      regAddr_q, regAddr_d;
   logic [7:0]             regWdata_q, regWdata_d;
   logic                   frameDone_q, frameDone_d;
   logic [7:0]             byteCount_q, byteCount_d;
   logic                   overrun_q, overrun_d;

   logic csS;
   logic validS;
   logic strobe;
   logic burstRoom;

   assign csS       = csSync_q[SYNC_STAGES-1];
   assign validS    = validSync_q[SYNC_STAGES-1];
   assign strobe    = validS & ~validPrev_q;
   assign burstRoom = (dataCnt_q < MAX_BURST_C);

`ifdef SPI_CMD_SEQ_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYC - 1);

   logic [TMR_W-1:0] timer_q, timer_d;
   logic             timeout_q, timeout_d;
   logic             timeoutHit;

   // The current cycle is the TIMEOUT_CYC-th consecutive one without a byte.
   assign timeoutHit = (state_q != IDLE) && !csS && !strobe && (timer_q == TIMER_LAST);
   assign timeout_o  = timeout_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         csSync_q    <= '1;
         validSync_q <= '0;
         validPrev_q <= 1'b0;
         state_q     <= IDLE;
         addr_q      <= '0;
         dataCnt_q   <= '0;
         regWe_q     <= 1'b0;
         regAddr_q   <= '0;
         regWdata_q  <= '0;
         frameDone_q <= 1'b0;
         byteCount_q <= '0;
         overrun_q   <= 1'b0;
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
         timer_q     <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         csSync_q    <= {csSync_q[SYNC_STAGES-2:0], spi_cs_i};
         validSync_q <= {validSync_q[SYNC_STAGES-2:0], byte_valid_i};
         validPrev_q <= validS;
         state_q     <= state_d;
         addr_q      <= addr_d;
         dataCnt_q   <= dataCnt_d;
         regWe_q     <= regWe_d;
         regAddr_q   <= regAddr_d;
         regWdata_q  <= regWdata_d;
         frameDone_q <= frameDone_d;
         byteCount_q <= byteCount_d;
         overrun_q   <= overrun_d;
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
         timer_q     <= timer_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   // A chip-select release always closes the frame, even if a byte arrives in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!csS) state_d = CMD;
         end
         CMD: begin
            if (csS)         state_d = IDLE;
            else if (strobe) state_d = byte_i[7] ? DATA : DISCARD;
         end
         DATA: begin
            if (csS)                        state_d = IDLE;
            else if (strobe && !burstRoom)  state_d = DISCARD;
         end
         DISCARD: begin
            if (csS) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
      if (timeoutHit) state_d = DISCARD;
`endif
   end

   always_comb begin
      addr_d      = addr_q;
      dataCnt_d   = dataCnt_q;
      regWe_d     = 1'b0;
      regAddr_d   = regAddr_q;
      regWdata_d  = regWdata_q;
      frameDone_d = 1'b0;
      byteCount_d = byteCount_q;
      overrun_d   = overrun_q;
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
      timer_d     = timer_q;
      timeout_d   = timeout_q;
`endif
      if (state_q == IDLE) begin
         if (!csS) begin
            byteCount_d = '0;
            overrun_d   = 1'b0;
            dataCnt_d   = '0;
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
            timer_d     = '0;
            timeout_d   = 1'b0;
`endif
         end
      end else if (csS) begin
         frameDone_d = 1'b1;
      end else begin
         if (strobe) begin
            if (byteCount_q != 8'hFF) byteCount_d = byteCount_q + 8'd1;
            if (state_q == CMD) begin
               addr_d = byte_i[ADDR_W-1:0];
            end else if (state_q == DATA) begin
               if (burstRoom) begin
                  regWe_d    = 1'b1;
                  regAddr_d  = addr_q;
                  regWdata_d = byte_i;
                  addr_d     = addr_q + ADDR_W'(1);
                  dataCnt_d  = dataCnt_q + CNT_W'(1);
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
         if (strobe) begin
            timer_d = '0;
         end else if (timeoutHit) begin
            timeout_d = 1'b1;
         end else begin
            timer_d = timer_q + TMR_W'(1);
         end
`endif
      end
   end

   assign regBus.regWe    = regWe_q;
   assign regBus.regAddr  = regAddr_q;
   assign regBus.regWdata = regWdata_q;
   assign busy_o          = (state_q != IDLE);
   assign frame_done_o    = frameDone_q;
   assign byte_count_o    = byteCount_q;
   assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed testbench for spi_cmd_sequencer: table-driven frames plus hand-written
// corner cases (latency, reset mid-frame, CS/strobe collision, idle strobes, timeout).
module tb_spi_cmd_sequencer;

   localparam int ADDR_W    = 7;
   localparam int MAX_BURST = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       spiCs;
   logic [7:0] byteIn;
   logic       byteValid;
   logic       busy;
   logic       frameDone;
   logic [7:0] byteCount;
   logic       overrun;
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
   logic       timeout;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_cmd_sequencer_if #(.ADDR_W(ADDR_W)) regBus ();

   spi_cmd_sequencer #(
      .ADDR_W      (ADDR_W),
      .MAX_BURST   (MAX_BURST),
      .SYNC_STAGES (2)
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (64)
`endif
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .spi_cs_i     (spiCs),
      .byte_i       (byteIn),
      .byte_valid_i (byteValid),
      .regBus       (regBus),
      .busy_o       (busy),
      .frame_done_o (frameDone),
      .byte_count_o (byteCount),
      .overrun_o    (overrun)
`ifdef SPI_CMD_SEQ_TIMEOUT_EN
      ,
      .timeout_o    (timeout)
`endif
   );

   // Write and frame-done monitor; records every strobe and flags back-to-back writes.
   logic [6:0] wrAddr[$];
   logic [7:0] wrData[$];
   int         doneCount    = 0;
   int         weViolations = 0;
   logic       prevWe       = 1'b0;

   always @(negedge clk) begin
      if (regBus.regWe) begin
         wrAddr.push_back(regBus.regAddr);
         wrData.push_back(regBus.regWdata);
      end
      if (regBus.regWe && prevWe) weViolations <= weViolations + 1;
      if (frameDone) doneCount <= doneCount + 1;
      prevWe <= regBus.regWe;
   end

   typedef struct packed {
      logic [19:0][7:0] bytes;
      logic [7:0]       n;
      logic [7:0]       expWrites;
      logic [6:0]       expAddr;
      logic [7:0]       expCount;
      logic             expOverrun;
   } vec_t;

   vec_t vecs[5];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sendByte(input logic [7:0] b);
      @(negedge clk);
      byteIn    = b;
      byteValid = 1'b1;
      tick(4);
      byteValid = 1'b0;
      tick(4);
   endtask

   task automatic csLow();
      @(negedge clk);
      spiCs = 1'b0;
      tick(5);
   endtask

   task automatic csHigh();
      @(negedge clk);
      spiCs = 1'b1;
      tick(6);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " regWe"},     32'(regBus.regWe),    32'h0);
      checkOutput({tag, " regAddr"},   32'(regBus.regAddr),  32'h0);
      checkOutput({tag, " regWdata"},  32'(regBus.regWdata), 32'h0);
      checkOutput({tag, " busy"},      32'(busy),            32'h0);
      checkOutput({tag, " frameDone"}, 32'(frameDone),       32'h0);
      checkOutput({tag, " byteCount"}, 32'(byteCount),       32'h0);
      checkOutput({tag, " overrun"},   32'(overrun),         32'h0);
   endtask

   task automatic applyStimulus(input int idx);
      int         startWr;
      int         startDone;
      int         nWr;
      logic [6:0] ea;
      startWr   = wrAddr.size();
      startDone = doneCount;
      csLow();
      checkOutput($sformatf("vec%0d start busy", idx),      32'(busy),      32'h1);
      checkOutput($sformatf("vec%0d start byteCount", idx), 32'(byteCount), 32'h0);
      checkOutput($sformatf("vec%0d start overrun", idx),   32'(overrun),   32'h0);
      for (int i = 0; i < int'(vecs[idx].n); i++) sendByte(vecs[idx].bytes[i]);
      csHigh();
      settle();
      nWr = wrAddr.size() - startWr;
      checkOutput($sformatf("vec%0d writes", idx), 32'(nWr), 32'(vecs[idx].expWrites));
      for (int i = 0; i < int'(vecs[idx].expWrites) && i < nWr; i++) begin
         ea = vecs[idx].expAddr + 7'(i);
         checkOutput($sformatf("vec%0d addr%0d", idx, i), 32'(wrAddr[startWr + i]), 32'(ea));
         checkOutput($sformatf("vec%0d data%0d", idx, i), 32'(wrData[startWr + i]),
                     32'(vecs[idx].bytes[i + 1]));
      end
      checkOutput($sformatf("vec%0d frameDone", idx), 32'(doneCount - startDone), 32'h1);
      checkOutput($sformatf("vec%0d byteCount", idx), 32'(byteCount), 32'(vecs[idx].expCount));
      checkOutput($sformatf("vec%0d overrun", idx),   32'(overrun),   32'(vecs[idx].expOverrun));
      checkOutput($sformatf("vec%0d busy end", idx),  32'(busy),      32'h0);
   endtask

   initial begin
      int startWr;
      int startDone;

      for (int v = 0; v < 5; v++) vecs[v] = '0;
      vecs[0].bytes[0] = 8'h85; vecs[0].bytes[1] = 8'hAA; vecs[0].bytes[2] = 8'h55;
      vecs[0].n = 8'd3; vecs[0].expWrites = 8'd2; vecs[0].expAddr = 7'h05;
      vecs[0].expCount = 8'd3; vecs[0].expOverrun = 1'b0;
      vecs[1].bytes[0] = 8'hFF; vecs[1].bytes[1] = 8'h01; vecs[1].bytes[2] = 8'h02;
      vecs[1].bytes[3] = 8'h03;
      vecs[1].n = 8'd4; vecs[1].expWrites = 8'd3; vecs[1].expAddr = 7'h7F;
      vecs[1].expCount = 8'd4; vecs[1].expOverrun = 1'b0;
      vecs[2].bytes[0] = 8'h80;
      for (int i = 1; i <= 18; i++) vecs[2].bytes[i] = 8'hA0 + 8'(i - 1);
      vecs[2].n = 8'd19; vecs[2].expWrites = 8'd16; vecs[2].expAddr = 7'h00;
      vecs[2].expCount = 8'd19; vecs[2].expOverrun = 1'b1;
      vecs[3].bytes[0] = 8'h12; vecs[3].bytes[1] = 8'h33; vecs[3].bytes[2] = 8'h44;
      vecs[3].n = 8'd3; vecs[3].expWrites = 8'd0; vecs[3].expAddr = 7'h00;
      vecs[3].expCount = 8'd3; vecs[3].expOverrun = 1'b0;
      vecs[4].n = 8'd0; vecs[4].expWrites = 8'd0; vecs[4].expAddr = 7'h00;
      vecs[4].expCount = 8'd0; vecs[4].expOverrun = 1'b0;

      rst       = 1'b1;
      spiCs     = 1'b1;
      byteIn    = 8'h00;
      byteValid = 1'b0;
      tick(3);
      checkResetState("reset");
      rst = 1'b0;
      tick(3);

      // Strobes with CS inactive must be ignored.
      startWr = wrAddr.size();
      sendByte(8'h85);
      sendByte(8'hAA);
      settle();
      checkOutput("idle writes", 32'(wrAddr.size() - startWr), 32'h0);
      checkOutput("idle busy", 32'(busy), 32'h0);
      checkOutput("idle byteCount", 32'(byteCount), 32'h0);

      for (int v = 0; v < 5; v++) applyStimulus(v);

      // Write appears exactly one cycle after the synchronized strobe and holds afterwards.
      csLow();
      sendByte(8'h90);
      @(negedge clk);
      byteIn    = 8'h5A;
      byteValid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("latency early regWe", 32'(regBus.regWe), 32'h0);
      @(negedge clk);
      checkOutput("latency regWe", 32'(regBus.regWe), 32'h1);
      checkOutput("latency addr", 32'(regBus.regAddr), 32'h10);
      checkOutput("latency data", 32'(regBus.regWdata), 32'h5A);
      @(negedge clk);
      checkOutput("latency pulse width", 32'(regBus.regWe), 32'h0);
      checkOutput("hold addr", 32'(regBus.regAddr), 32'h10);
      checkOutput("hold data", 32'(regBus.regWdata), 32'h5A);
      tick(2);
      byteValid = 1'b0;
      tick(4);
      csHigh();

      // A byte arriving together with CS release is dropped and not counted.
      csLow();
      sendByte(8'h81);
      startWr   = wrAddr.size();
      startDone = doneCount;
      @(negedge clk);
      byteIn    = 8'h77;
      byteValid = 1'b1;
      spiCs     = 1'b1;
      tick(4);
      byteValid = 1'b0;
      tick(4);
      settle();
      checkOutput("collision writes", 32'(wrAddr.size() - startWr), 32'h0);
      checkOutput("collision byteCount", 32'(byteCount), 32'h1);
      checkOutput("collision frameDone", 32'(doneCount - startDone), 32'h1);

      // Reset mid-frame discards the frame without a FRAME_DONE.
      csLow();
      sendByte(8'h83);
      sendByte(8'h01);
      startDone = doneCount;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkResetState("midreset");
      rst = 1'b0;
      startWr = wrAddr.size();
      sendByte(8'h22);
      sendByte(8'h33);
      settle();
      checkOutput("midreset frameDone", 32'(doneCount - startDone), 32'h0);
      checkOutput("post-reset writes", 32'(wrAddr.size() - startWr), 32'h0);
      csHigh();

`ifdef SPI_CMD_SEQ_TIMEOUT_EN
      csLow();
      checkOutput("timeout start", 32'(timeout), 32'h0);
      sendByte(8'h80);
      tick(100);
      startWr = wrAddr.size();
      sendByte(8'h11);
      settle();
      checkOutput("timeout flag", 32'(timeout), 32'h1);
      checkOutput("timeout writes", 32'(wrAddr.size() - startWr), 32'h0);
      startDone = doneCount;
      csHigh();
      settle();
      checkOutput("timeout frameDone", 32'(doneCount - startDone), 32'h1);
`endif

      settle();
      checkOutput("back-to-back regWe", 32'(weViolations), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Consumes received bytes from the SPI receive buffer (BYTE = buffer output, BYTE_VALID = its changed flag, SPI_CS = raw chip select) and decodes them into register-write frames.
- Drives a single-port register-file write interface.
- Runs on the system clock; SPI-domain inputs are synchronized internally.
- Sits between the SPI front end and the configuration register bank.

Parameters:
- ADDR_W, 7, register address width; command byte carries start address in bits [ADDR_W-1:0], ADDR_W <= 7.
- MAX_BURST, 16, max data bytes written per frame; later bytes are discarded.
- SYNC_STAGES, 2, flip-flop stages on SPI_CS and BYTE_VALID, >= 2.
- TIMEOUT_CYC, 4096, idle CLK cycles before frame abort (optional feature only).

Ports:
- CLK  in  1  system clock, single clock domain.
- RST  in  1  synchronous, active-high reset.
- SPI_CS  in  1  raw chip select, active low, asynchronous to CLK.
- BYTE  in  8  received byte; stable from BYTE_VALID rise until the next byte completes.
- BYTE_VALID  in  1  changed flag, asynchronous; high for >= 4 SPI clocks per byte.
- REG_WE  out  1  one-cycle write strobe.
- REG_ADDR  out  ADDR_W  write address.
- REG_WDATA  out  8  write data.
- BUSY  out  1  high while a frame is open (state != IDLE).
- FRAME_DONE  out  1  one-cycle pulse when a frame closes.
- BYTE_COUNT  out  8  bytes received in last/current frame, saturating at 255.
- OVERRUN  out  1  sticky; set when a frame exceeds MAX_BURST; cleared at next frame start.

Behaviour:
- Reset (RST=1 at CLK edge): state=IDLE; REG_WE=0, REG_ADDR=0, REG_WDATA=0, BUSY=0, FRAME_DONE=0, BYTE_COUNT=0, OVERRUN=0; synchronizers cleared to CS=1 (inactive), VALID=0.
- Reset mid-frame discards the frame; no REG_WE and no FRAME_DONE are emitted.
- Clocking requirement: CLK >= 4x SPI clock.
- cs_s and valid_s are the synchronized signals.
- Byte strobe: cycle T where valid_s=1 and its previous value=0. BYTE is sampled in cycle T.
- Frame start: cs_s falls. Frame end: cs_s rises.
- FSM states:
  - IDLE: cs_s=0 -> CMD; clear BYTE_COUNT and OVERRUN.
  - CMD: on strobe, latch start address = BYTE[ADDR_W-1:0], BYTE_COUNT += 1.
    - BYTE[7]=1 -> DATA.
    - BYTE[7]=0 -> DISCARD (no-op command).
  - DATA: on strobe, BYTE_COUNT += 1.
    - Fewer than MAX_BURST data bytes written so far: REG_WE=1 in cycle T+1 with REG_ADDR = current address, REG_WDATA = sampled BYTE; then address += 1, wrapping mod 2^ADDR_W.
    - Otherwise: set OVERRUN, go to DISCARD, no write.
  - DISCARD: strobes only increment BYTE_COUNT.
  - Any non-IDLE state: cs_s rises -> IDLE with FRAME_DONE=1 for one cycle; BYTE_COUNT and OVERRUN hold until next frame start.
- Write latency: exactly one CLK after strobe detection; REG_WE never high for two consecutive cycles.
- REG_ADDR and REG_WDATA hold their last values when REG_WE=0.
- Simultaneous cs_s rise and strobe in the same cycle: frame end wins; the byte is dropped and not counted.
- A frame with zero bytes (CS pulse only) still gives FRAME_DONE with BYTE_COUNT=0.
- Strobe while in IDLE: ignored.
- BYTE_COUNT saturates at 255 and does not wrap.

Optional Feature:
- Macro: SPI_CMD_SEQ_TIMEOUT_EN.
- Defined:
  - A counter resets on every strobe and on frame start.
  - In CMD/DATA/DISCARD, reaching TIMEOUT_CYC idle cycles forces state -> DISCARD and sets an extra output TIMEOUT (1-bit, sticky, cleared at next frame start); writes stop.
  - FRAME_DONE is still issued at cs_s rise.
- Undefined: no counter and no TIMEOUT port; frames stay open indefinitely until cs_s rises.

Test Plan:
- CS low; bytes 0x85, 0xAA, 0x55; CS high -> REG_WE pulses at addr 0x05 data 0xAA and addr 0x06 data 0x55, each 1 cycle after strobe; FRAME_DONE pulse, BYTE_COUNT=3, OVERRUN=0.
- Command 0xFF then 3 data bytes -> writes at 0x7F, 0x00, 0x01 (wrap-around).
- Command 0x80 then 18 data bytes, MAX_BURST=16 -> 16 writes at 0x00..0x0F; OVERRUN=1, BYTE_COUNT=19; next frame start clears OVERRUN.
- Command 0x12 (W=0) then 2 bytes -> no REG_WE; BYTE_COUNT=3; FRAME_DONE pulse.
- RST asserted after command 0x83 and 1 data byte -> all outputs return to reset values next cycle; following bytes before a new CS fall produce no writes.
- With SPI_CMD_SEQ_TIMEOUT_EN, TIMEOUT_CYC=64: command 0x80, then 100 idle cycles, then byte 0x11 -> TIMEOUT=1, no write of 0x11; FRAME_DONE at CS rise.
